sr_latch_bank_ctrl: RTL and testbench

- Sequencer for a bank of N external NOR SR latches (S, R in; Q out per latch). Accepts one set/reset/toggle command at a time over a valid/ready handshake and converts it into a guarded S or R pulse.
- Waits a settle gap, then reads Q back to confirm the write.
- Guarantees the invalid S=R=1 condition is never driven and that at most one latch is pulsed at a time.

---
 rtl/sr_latch_bank_ctrl.sv | 128 ++++++++++++
 tb/tb_sr_latch_bank_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank_ctrl.sv
// Sequencer for a bank of NOR SR latches: one command at a time becomes a guarded
// S or R pulse, followed by a settle gap and a Q readback check.
module sr_latch_bank_ctrl #(
  parameter int N         = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic [N-1:0]     S,
  output logic [N-1:0]     R,
  input  logic [N-1:0]     Q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W:0]   N_LIM    = (IDX_W+1)'(N);
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_exp_set;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_idx_ok;
  logic               w_q_acc;
  logic               w_q_cur;
  logic               w_exp_set;
  logic [N-1:0]       w_sel;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_idx_ok  = ({1'b0, cmd_idx} < N_LIM);
  assign w_q_acc   = Q[cmd_idx];
  assign w_q_cur   = Q[r_idx];
  assign w_sel     = N'(1) << cmd_idx;

  // Toggle resolves to RESET only on a definite 1; 0 or unknown resolves to SET.
  always_comb begin
    w_exp_set = 1'b1;
    if (cmd_op == OP_RESET)
      w_exp_set = 1'b0;
    else if ((cmd_op == OP_TOGGLE) && (w_q_acc == 1'b1))
      w_exp_set = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      S       <= '0;
      R       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx     <= cmd_idx;
            r_exp_set <= w_exp_set;
            if (cmd_op == OP_NOP) begin
              r_state <= CHECK;
              done    <= 1'b1;
            end else if (!w_idx_ok) begin
              r_state <= CHECK;
              done    <= 1'b1;
              err     <= 1'b1;
              err_idx <= cmd_idx;
            end else begin
              r_state <= DRIVE;
              r_cnt   <= PULSE_LD;
              if (w_exp_set) S <= w_sel;
              else           R <= w_sel;
            end
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            S       <= '0;
            R       <= '0;
            r_cnt   <= GAP_LD;
            r_state <= SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= CHECK;
            done    <= 1'b1;
            // An unknown readback falls into the mismatch branch.
            if (w_q_cur == r_exp_set) begin
              err <= 1'b0;
            end else begin
              err     <= 1'b1;
              err_idx <= r_idx;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CHECK:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl with a behavioural NOR-latch bank on S/R/Q
// and a stuck-at-0 mask for readback faults.
module tb_sr_latch_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_idx;
  logic [7:0] S, R, Q;
  logic       busy, done, err;
  logic [2:0] err_idx;

  logic [7:0] q_lat;
  logic [7:0] stuck0 = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sr_latch_bank_ctrl #(.N(8), .IDX_W(3), .PULSE_CYC(2), .GAP_CYC(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .S(S), .R(R), .Q(Q),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  // NOR latch bank: S sets, R clears, otherwise hold.
  always @(S or R) begin
    for (int i = 0; i < 8; i++) begin
      if (S[i])      q_lat[i] = 1'b1;
      else if (R[i]) q_lat[i] = 1'b0;
    end
  end
  assign Q = q_lat & ~stuck0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Guard properties sampled mid-cycle on every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("inv_s_and_r", {24'd0, S & R}, 32'd0);
      check("inv_onehot", ($countones(S | R) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("inv_idle_quiet", (!busy && ((S | R) != 8'h00)) ? 32'd1 : 32'd0, 32'd0);
      check("inv_done_busy", (done && !busy) ? 32'd1 : 32'd0, 32'd0);
      check("inv_err_done", (err && !done) ? 32'd1 : 32'd0, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int edges);
    logic acc;
    edges = 0;
    do begin
      acc = cmd_valid && cmd_ready;
      tick();
      edges++;
    end while (!acc && edges < 50);
    check("accept_seen", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_done(output logic e, output logic [7:0] ss, output logic [7:0] rs);
    int n = 0;
    ss = 8'h00;
    rs = 8'h00;
    while (done !== 1'b1 && n < 50) begin
      ss |= S;
      rs |= R;
      tick();
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    e = err;
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [7:0] exp_s, input logic [7:0] exp_r, input logic exp_err);
    int edges;
    logic e;
    logic [7:0] ss, rs;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    wait_accept(edges);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_idx   = 3'd0;
    wait_done(e, ss, rs);
    check({tag, "_s"}, {24'd0, ss}, {24'd0, exp_s});
    check({tag, "_r"}, {24'd0, rs}, {24'd0, exp_r});
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    if (exp_err) check({tag, "_erridx"}, {29'd0, err_idx}, {29'd0, idx});
    tick();
  endtask

  initial begin
    int edges;
    logic e;
    logic [7:0] ss, rs;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = 3'd0;
    tick(); tick();
    check("rst_s", {24'd0, S}, 32'd0);
    check("rst_r", {24'd0, R}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_erridx", {29'd0, err_idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: SET idx 3 with cycle-exact timing; inputs change right after accept.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 3'd3;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b10; cmd_idx = 3'd0;
    check("t1_s_c1", {24'd0, S}, 32'h08);
    check("t1_r_c1", {24'd0, R}, 32'h00);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready_c1", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("t1_s_c2", {24'd0, S}, 32'h08);
    tick();
    check("t1_s_gap", {24'd0, S | R}, 32'h00);
    check("t1_done_gap", {31'd0, done}, 32'd0);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_q3", {31'd0, Q[3]}, 32'd1);
    tick();
    check("t1_done_off", {31'd0, done}, 32'd0);
    check("t1_ready_end", {31'd0, cmd_ready}, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: RESET then two TOGGLEs on idx 3.
    do_cmd("t2_reset", 2'b10, 3'd3, 8'h00, 8'h08, 1'b0);
    check("t2_q_after_reset", {31'd0, Q[3]}, 32'd0);
    do_cmd("t2_tog1", 2'b11, 3'd3, 8'h08, 8'h00, 1'b0);
    check("t2_q_after_tog1", {31'd0, Q[3]}, 32'd1);
    do_cmd("t2_tog2", 2'b11, 3'd3, 8'h00, 8'h08, 1'b0);
    check("t2_q_after_tog2", {31'd0, Q[3]}, 32'd0);

    // 3: TOGGLE on a never-written latch resolves to SET.
    do_cmd("t3_tog5", 2'b11, 3'd5, 8'h20, 8'h00, 1'b0);
    check("t3_q5", {31'd0, Q[5]}, 32'd1);

    // 4: stuck-at-0 readback, then a NOP leaves err_idx alone.
    stuck0 = 8'h04;
    do_cmd("t4_set2", 2'b01, 3'd2, 8'h04, 8'h00, 1'b1);
    do_cmd("t4_nop", 2'b00, 3'd6, 8'h00, 8'h00, 1'b0);
    check("t4_erridx_hold", {29'd0, err_idx}, 32'd2);
    stuck0 = 8'h00;

    // 5: valid held high across two commands.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 3'd1;
    wait_accept(edges);
    cmd_idx = 3'd6;
    wait_accept(edges);
    check("t5_second_accept_gap", edges, 32'd5);
    cmd_valid = 1'b0;
    wait_done(e, ss, rs);
    check("t5_s6", {24'd0, ss}, 32'h40);
    check("t5_err", {31'd0, e}, 32'd0);
    tick();
    check("t5_q", {24'd0, Q & 8'h42}, 32'h42);

    // 6: reset during the second DRIVE cycle discards the command.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 3'd4;
    wait_accept(edges);
    cmd_valid = 1'b0;
    check("t6_s_c1", {24'd0, S}, 32'h10);
    tick();
    rst = 1'b1;
    tick();
    check("t6_s_rst", {24'd0, S}, 32'h00);
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    check("t6_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", {30'd0, done, err}, 32'd0);
    end
    do_cmd("t6_set4", 2'b01, 3'd4, 8'h10, 8'h00, 1'b0);
    check("t6_q4", {31'd0, Q[4]}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
